// File: rtl/cps_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cps_pkg                                                                  |
// | Shared FSM state encoding and image-size helper for the CPS loader.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHIPRST = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_GAP     = 3'd4
  } cps_state_t;

  function automatic int nbits(input int n_out, input int sel_w);
    return n_out * sel_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cps_bit_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cps_bit_timer                                                            |
// | Per-bit phase counter: CLK_DIV low cycles followed by CLK_DIV high.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cps_bit_timer
  import cps_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_low_start,
  output logic o_rise,
  output logic o_sample
);

  localparam int              c_cw       = $clog2(2 * CLK_DIV);
  localparam logic [c_cw-1:0] c_rise_cnt = c_cw'(CLK_DIV - 1);
  localparam logic [c_cw-1:0] c_last_cnt = c_cw'(2 * CLK_DIV - 1);

  logic [c_cw-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == c_last_cnt)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Strobes describe the current cycle; the loader uses them to set the
  // registered pin values for the following cycle.
  assign o_low_start = i_en && (r_cnt == '0);
  assign o_rise      = i_en && (r_cnt == c_rise_cnt);
  assign o_sample    = i_en && (r_cnt == c_last_cnt);

endmodule
`default_nettype wire

// File: rtl/cps_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cps_loader                                                               |
// | Serially loads a cross-point-switch select table and verifies readback.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cps_loader
  import cps_pkg::*;
#(
  parameter int N_OUT   = 16,
  parameter int SEL_W   = 5,
  parameter int CLK_DIV = 4,
  parameter int RST_CYC = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(N_OUT)-1:0] cfg_addr,
  input  logic [SEL_W-1:0]         cfg_data,
  input  logic                     start,
  input  logic                     hw_reset_req,
  output logic                     busy,
  output logic                     done,
  output logic                     verify_err,
  output logic                     CPS_clk,
  output logic                     CPS_ce_n,
  output logic                     CPS_datain,
  input  logic                     CPS_dataout,
  output logic                     CPS_reset_n,
  output logic                     CPS_update_n
);

  localparam int              NBITS      = nbits(N_OUT, SEL_W);
  localparam int              c_bw       = $clog2(NBITS);
  localparam logic [c_bw-1:0] c_last_bit = c_bw'(NBITS - 1);
  localparam int              c_cnt_max  = (RST_CYC > CLK_DIV) ? RST_CYC : CLK_DIV;
  localparam int              c_cw       = $clog2(c_cnt_max);
  localparam logic [c_cw-1:0] c_rst_last = c_cw'(RST_CYC - 1);
  localparam logic [c_cw-1:0] c_div_last = c_cw'(CLK_DIV - 1);

  logic [N_OUT-1:0][SEL_W-1:0] r_table;
  logic [NBITS-1:0]            r_shift;
  logic [NBITS-1:0]            r_prev;
  logic                        r_prev_valid;
  logic [c_bw-1:0]             r_bit;
  logic [c_cw-1:0]             r_cnt;
  cps_state_t                  r_state;
  logic                        r_sync1, r_sync2;
  logic r_cps_clk, r_ce_n, r_datain, r_reset_n, r_update_n;
  logic r_busy, r_done, r_verify_err;
  logic w_low_start, w_rise, w_sample;

  cps_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .clk         (clk),
    .rst         (reset),
    .i_en        (r_state == ST_SHIFT),
    .o_low_start (w_low_start),
    .o_rise      (w_rise),
    .o_sample    (w_sample)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) r_table[i] <= SEL_W'(i);
    end else if (cfg_we) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= CPS_dataout;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cps_clk    <= 1'b0;
      r_ce_n       <= 1'b1;
      r_datain     <= 1'b0;
      r_reset_n    <= 1'b0;
      r_update_n   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_verify_err <= 1'b0;
      r_prev_valid <= 1'b0;
      r_shift      <= '0;
      r_prev       <= '0;
      r_bit        <= '0;
      r_cnt        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cps_clk  <= 1'b0;
          r_ce_n     <= 1'b1;
          r_datain   <= 1'b0;
          r_reset_n  <= 1'b1;
          r_update_n <= 1'b1;
          if (start) begin
            r_shift      <= r_table;
            r_busy       <= 1'b1;
            r_verify_err <= 1'b0;
            r_bit        <= '0;
            r_cnt        <= '0;
            if (hw_reset_req) begin
              r_state   <= ST_CHIPRST;
              r_reset_n <= 1'b0;
            end else begin
              r_state  <= ST_SHIFT;
              r_ce_n   <= 1'b0;
              r_datain <= r_table[N_OUT-1][SEL_W-1];
            end
          end
        end
        ST_CHIPRST: begin
          if (r_cnt == c_rst_last) begin
            r_reset_n    <= 1'b1;
            r_prev_valid <= 1'b0;
            r_state      <= ST_SHIFT;
            r_ce_n       <= 1'b0;
            r_datain     <= r_shift[NBITS-1];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          // Both images rotate rather than shift so they are intact after
          // the last bit: r_shift becomes the next reference image.
          if (w_low_start) r_shift <= {r_shift[NBITS-2:0], r_shift[NBITS-1]};
          if (w_rise) r_cps_clk <= 1'b1;
          if (w_sample) begin
            r_cps_clk <= 1'b0;
            r_prev    <= {r_prev[NBITS-2:0], r_prev[NBITS-1]};
            if (r_prev_valid && (r_sync2 != r_prev[NBITS-1])) r_verify_err <= 1'b1;
            if (r_bit == c_last_bit) begin
              r_state    <= ST_LATCH;
              r_ce_n     <= 1'b1;
              r_datain   <= 1'b0;
              r_update_n <= 1'b0;
              r_cnt      <= '0;
            end else begin
              r_bit    <= r_bit + 1'b1;
              r_datain <= r_shift[NBITS-1];
            end
          end
        end
        ST_LATCH: begin
          if (r_cnt == c_div_last) begin
            r_update_n <= 1'b1;
            r_state    <= ST_GAP;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == c_div_last) begin
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_prev_valid <= 1'b1;
            r_prev       <= r_shift;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign verify_err   = r_verify_err;
  assign CPS_clk      = r_cps_clk;
  assign CPS_ce_n     = r_ce_n;
  assign CPS_datain   = r_datain;
  assign CPS_reset_n  = r_reset_n;
  assign CPS_update_n = r_update_n;

endmodule
`default_nettype wire

// File: tb/tb_cps_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cps_loader                                                            |
// | Directed bench: scoreboarded serial stream, timing and readback checks.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cps_loader;

  localparam int N_OUT   = 4;
  localparam int SEL_W   = 2;
  localparam int CLK_DIV = 3;
  localparam int RST_CYC = 8;
  localparam int NB      = N_OUT * SEL_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [SEL_W-1:0] cfg_data;
  logic             start, hw_reset_req;
  logic             busy, done, verify_err;
  logic             CPS_clk, CPS_ce_n, CPS_datain, CPS_dataout, CPS_reset_n, CPS_update_n;

  int   n_asserts = 0;
  int   n_fail    = 0;
  logic sb[$];
  logic [SEL_W-1:0] tb_table [N_OUT];

  // Chain model: presents bit k of the previous load from the start of bit k
  // until CPS_clk falls, then advances.
  logic [NB-1:0] chain = '0;
  logic          latched = 1'b0;
  logic          prev_clk = 1'b0;
  int            fall_cnt = 0;
  logic          flip_en;
  int            flip_idx;

  cps_loader #(.N_OUT(N_OUT), .SEL_W(SEL_W), .CLK_DIV(CLK_DIV), .RST_CYC(RST_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .start        (start),
    .hw_reset_req (hw_reset_req),
    .busy         (busy),
    .done         (done),
    .verify_err   (verify_err),
    .CPS_clk      (CPS_clk),
    .CPS_ce_n     (CPS_ce_n),
    .CPS_datain   (CPS_datain),
    .CPS_dataout  (CPS_dataout),
    .CPS_reset_n  (CPS_reset_n),
    .CPS_update_n (CPS_update_n)
  );

  always #5 clk = ~clk;

  assign CPS_dataout = chain[NB-1] ^ (flip_en && (fall_cnt == flip_idx));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic e;
    if (CPS_clk && !prev_clk) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("datain", {31'd0, CPS_datain}, {31'd0, e});
      end
      latched <= CPS_datain;
    end
    if (!CPS_clk && prev_clk) begin
      chain    <= {chain[NB-2:0], latched};
      fall_cnt <= fall_cnt + 1;
    end
    if (CPS_ce_n) fall_cnt <= 0;
    if (!CPS_reset_n) chain <= '0;
    prev_clk <= CPS_clk;
  end

  task automatic push_model();
    for (int e = N_OUT - 1; e >= 0; e--)
      for (int b = SEL_W - 1; b >= 0; b--) sb.push_back(tb_table[e][b]);
  endtask

  task automatic push_lit(input logic [NB-1:0] v);
    for (int i = NB - 1; i >= 0; i--) sb.push_back(v[i]);
  endtask

  task automatic write_cfg(input logic [1:0] a, input logic [SEL_W-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tb_table[a] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_clk"},      {31'd0, CPS_clk},      32'd0);
    check({tag, "_ce_n"},     {31'd0, CPS_ce_n},     32'd1);
    check({tag, "_datain"},   {31'd0, CPS_datain},   32'd0);
    check({tag, "_reset_n"},  {31'd0, CPS_reset_n},  32'd0);
    check({tag, "_update_n"}, {31'd0, CPS_update_n}, 32'd1);
    check({tag, "_busy"},     {31'd0, busy},         32'd0);
    check({tag, "_done"},     {31'd0, done},         32'd0);
    check({tag, "_verr"},     {31'd0, verify_err},   32'd0);
  endtask

  // Starts a load and follows it to done, counting cycles from the start cycle.
  task automatic run_load(input string tag, input logic hw, input int exp_lat,
                          input int mid_start_at, input int mid_we_at,
                          input logic [SEL_W-1:0] we_data);
    int lat, upd, rlow;
    logic busy_bad, v1;
    upd = 0; rlow = 0; busy_bad = 1'b0;
    @(negedge clk);
    start = 1'b1; hw_reset_req = hw;
    @(negedge clk);
    start = 1'b0; hw_reset_req = 1'b0;
    lat = 1;
    v1  = verify_err;
    while (!done && lat < 300) begin
      if (!busy) busy_bad = 1'b1;
      if (!CPS_update_n) upd++;
      if (!CPS_reset_n && CPS_ce_n) rlow++;
      start = (lat == mid_start_at);
      if (lat == mid_we_at) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = we_data;
        tb_table[0] = we_data;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0; cfg_we = 1'b0;
    check({tag, "_latency"},   lat, exp_lat);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_busy_gap"},  {31'd0, busy_bad}, 32'd0);
    check({tag, "_update_n"},  upd, CLK_DIV);
    check({tag, "_chip_rst"},  rlow, hw ? RST_CYC : 0);
    check({tag, "_verr_clr"},  {31'd0, v1}, 32'd0);
    check({tag, "_sb_empty"},  sb.size(), 0);
    check({tag, "_ce_idle"},   {31'd0, CPS_ce_n}, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic upd_seen, done_seen;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; hw_reset_req = 1'b0; flip_en = 1'b0; flip_idx = 0;
    for (int i = 0; i < N_OUT; i++) tb_table[i] = SEL_W'(i);
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_n_release", {31'd0, CPS_reset_n}, 32'd1);

    write_cfg(2'd0, 2'd3);
    write_cfg(2'd1, 2'd2);
    write_cfg(2'd2, 2'd1);
    write_cfg(2'd3, 2'd0);

    push_lit(8'b0001_1011);
    run_load("A", 1'b0, 55, 0, 0, '0);
    check("A_verr", {31'd0, verify_err}, 32'd0);

    push_model();
    run_load("B_hw", 1'b1, 63, 0, 0, '0);
    check("B_verr", {31'd0, verify_err}, 32'd0);

    push_model();
    run_load("C_readback", 1'b0, 55, 0, 0, '0);
    check("C_verr", {31'd0, verify_err}, 32'd0);

    flip_en = 1'b1; flip_idx = 3;
    push_model();
    run_load("D_flip", 1'b0, 55, 0, 0, '0);
    flip_en = 1'b0;
    check("D_verr", {31'd0, verify_err}, 32'd1);
    repeat (10) @(negedge clk);
    check("D_verr_held", {31'd0, verify_err}, 32'd1);

    push_model();
    run_load("E_midwrite", 1'b0, 55, 20, 25, 2'd0);
    check("E_verr", {31'd0, verify_err}, 32'd0);

    push_model();
    run_load("F_newval", 1'b0, 55, 0, 0, '0);
    check("F_verr", {31'd0, verify_err}, 32'd0);

    // Abort during the low phase of bit 5.
    push_model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (32) @(negedge clk);
    check("G_bits_sent", sb.size(), 3);
    reset = 1'b1;
    #1;
    check_reset_vals("G_abort");
    upd_seen = 1'b0; done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (!CPS_update_n) upd_seen = 1'b1;
      if (done) done_seen = 1'b1;
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!CPS_update_n) upd_seen = 1'b1;
      if (done) done_seen = 1'b1;
    end
    check("G_no_update", {31'd0, upd_seen}, 32'd0);
    check("G_no_done", {31'd0, done_seen}, 32'd0);
    check("G_busy_idle", {31'd0, busy}, 32'd0);
    sb.delete();
    for (int i = 0; i < N_OUT; i++) tb_table[i] = SEL_W'(i);

    push_lit(8'b1110_0100);
    run_load("H_identity", 1'b0, 55, 0, 0, '0);
    check("H_verr", {31'd0, verify_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
